// File: rtl/regfile_scrub.sv
// General-purpose register file: two combinational read ports, one write port, optional zero register and bypass.
// Reads have zero latency and writes land on the next edge. After reset, busy stays high for NREGS cycles; writes made during that time are dropped.
module regfile_scrub #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int LED_REG  = 1,
    parameter int LED_W    = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic [AW-1:0]    rd,
    input  logic [XLEN-1:0]  data,
    input  logic             reg_write,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             busy,
    output logic [LED_W-1:0] led
);

    typedef enum logic {SCRUB, READY} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW-1:0] LED_IDX  = AW'(LED_REG);

    state_t          r_state;
    logic [AW-1:0]   r_scnt;
    logic            r_busy;
    logic [XLEN-1:0] r_regs [NREGS];

    logic w_wr_ok;
    assign w_wr_ok = reg_write && !((ZERO_REG != 0) && (rd == '0));

    // Register contents are deliberately left out of the reset branch; the scrub clears them afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= SCRUB;
            r_scnt  <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                SCRUB: begin
                    r_regs[r_scnt] <= '0;
                    r_scnt         <= r_scnt + AW'(1);
                    if (r_scnt == LAST_IDX) begin
                        r_state <= READY;
                        r_busy  <= 1'b0;
                    end
                end
                READY: begin
                    if (w_wr_ok) r_regs[rd] <= data;
                end
                default: begin
                    r_state <= SCRUB;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
        if (r_busy)
            return '0;
        else if ((ZERO_REG != 0) && (a == '0))
            return '0;
        else if ((BYPASS != 0) && w_wr_ok && (rd == a))
            return data;
        else
            return r_regs[a];
    endfunction

    always_comb begin
        rs1_data = read_port(rs1);
        rs2_data = read_port(rs2);
    end

    assign busy = r_busy;
    // The LED mirror reads stored state only, so a same-cycle write does not show up here.
    assign led  = r_busy ? '1 : ~r_regs[LED_IDX][LED_W-1:0];

endmodule

// File: tb/tb_regfile_scrub.sv
module tb_regfile_scrub;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [31:0] data = '0;
    logic        reg_write = 1'b0;
    logic [31:0] a_rs1, a_rs2, b_rs1, b_rs2;
    logic        a_busy, b_busy;
    logic [5:0]  a_led, b_led;

    logic [2:0]  c_rs1 = '0, c_rs2 = '0, c_rd = '0;
    logic [15:0] c_data = '0;
    logic        c_we = 1'b0;
    logic [15:0] c_rs1_data, c_rs2_data;
    logic        c_busy;
    logic [5:0]  c_led;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    regfile_scrub #(.BYPASS(1)) dut_a (
        .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd), .data(data),
        .reg_write(reg_write), .rs1_data(a_rs1), .rs2_data(a_rs2), .busy(a_busy), .led(a_led)
    );

    regfile_scrub #(.BYPASS(0)) dut_b (
        .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd), .data(data),
        .reg_write(reg_write), .rs1_data(b_rs1), .rs2_data(b_rs2), .busy(b_busy), .led(b_led)
    );

    regfile_scrub #(.XLEN(16), .NREGS(8), .AW(3)) dut_c (
        .clock(clock), .reset(reset), .rs1(c_rs1), .rs2(c_rs2), .rd(c_rd), .data(c_data),
        .reg_write(c_we), .rs1_data(c_rs1_data), .rs2_data(c_rs2_data), .busy(c_busy), .led(c_led)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] a1, a2;   // bypassing instance
        logic [31:0] b1, b2;   // non-bypassing instance
        logic [5:0]  led;
    } vec_t;

    vec_t vecs[8];

    // Counts edges after reset release until the busy signals drop; returns 999 if they never do.
    task automatic scrub_count(output int na, output int nb, output int nc);
        na = 999; nb = 999; nc = 999;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clock); #1;
            if (!a_busy && na == 999) na = e;
            if (!b_busy && nb == 999) nb = e;
            if (!c_busy && nc == 999) nc = e;
            if (na != 999 && nb != 999 && nc != 999) break;
        end
    endtask

    initial begin
        int na, nb, nc;

        vecs[0] = '{1'b1, 5'd1, 32'h15,       5'd1, 5'd2,  32'h15,       32'h0,        32'h0,        32'h0,  6'h3F};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd1, 5'd1,  32'h15,       32'h15,       32'h15,       32'h15, 6'h2A};
        vecs[2] = '{1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,  6'h2A};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd1,  32'hDEADBEEF, 32'h15,       32'hDEADBEEF, 32'h15, 6'h2A};
        vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 6'h2A};
        vecs[5] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,  6'h2A};
        vecs[6] = '{1'b1, 5'd1, 32'h2A,       5'd1, 5'd3,  32'h2A,       32'h0,        32'h15,       32'h0,  6'h2A};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        5'd1, 5'd31, 32'h2A,       32'h0,        32'h2A,       32'h0,  6'h15};

        // Two reset edges, then release and time the scrub.
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        chk("busy_on_reset_a", 32'(a_busy), 32'd1);
        chk("busy_on_reset_c", 32'(c_busy), 32'd1);
        @(posedge clock); #1;
        chk("rs1_zero_busy", a_rs1, 32'h0);
        chk("led_ones_busy", 32'(a_led), 32'h3F);
        @(negedge clock); reset = 1'b0;
        scrub_count(na, nb, nc);
        chk("scrub_len_a", 32'(na), 32'd32);
        chk("scrub_len_b", 32'(nb), 32'd32);
        chk("scrub_len_c", 32'(nc), 32'd8);

        @(negedge clock);
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r); rs2 = 5'(31 - r); #1;
            chk($sformatf("scrubbed_a_r%0d", r), a_rs1 | a_rs2, 32'h0);
            chk($sformatf("scrubbed_b_r%0d", r), b_rs1 | b_rs2, 32'h0);
        end
        chk("led_after_scrub", 32'(a_led), 32'h3F);
        chk("led_after_scrub_c", 32'(c_led), 32'h3F);

        // Same stimulus to both instances; only bypass differs.
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            reg_write = vecs[i].we; rd = vecs[i].rd; data = vecs[i].data;
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
            #1;
            chk($sformatf("v%0d_a_rs1", i), a_rs1, vecs[i].a1);
            chk($sformatf("v%0d_a_rs2", i), a_rs2, vecs[i].a2);
            chk($sformatf("v%0d_b_rs1", i), b_rs1, vecs[i].b1);
            chk($sformatf("v%0d_b_rs2", i), b_rs2, vecs[i].b2);
            chk($sformatf("v%0d_led", i), 32'(a_led), 32'(vecs[i].led));
        end
        @(negedge clock); reg_write = 1'b0;

        // Narrow instance: write with same-cycle bypass on rs2, then stored readback.
        c_we = 1'b1; c_rd = 3'd7; c_data = 16'hA5A5; c_rs2 = 3'd7; #1;
        chk("c_bypass_rs2", 32'(c_rs2_data), 32'hA5A5);
        @(negedge clock); c_we = 1'b0; #1;
        chk("c_stored_rs2", 32'(c_rs2_data), 32'hA5A5);

        // Reset from READY, then reset again ten edges into the scrub, with a write held throughout.
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        chk("busy_mid_scrub", 32'(a_busy), 32'd1);
        @(negedge clock); reset = 1'b1; reg_write = 1'b1; rd = 5'd3; data = 32'h77;
        @(negedge clock); reset = 1'b0;
        scrub_count(na, nb, nc);
        reg_write = 1'b0;
        chk("rescrub_len_a", 32'(na), 32'd32);
        chk("rescrub_len_b", 32'(nb), 32'd32);
        @(negedge clock); rs1 = 5'd3; rs2 = 5'd7; #1;
        chk("dropped_write_a", a_rs1, 32'h0);
        chk("dropped_write_b", b_rs1, 32'h0);
        chk("r7_cleared", a_rs2, 32'h0);
        chk("led_after_rescrub", 32'(a_led), 32'h3F);
        c_rs2 = 3'd7; #1;
        chk("c_r7_cleared", 32'(c_rs2_data), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
